pulse_event_capture: RTL and testbench

Downstream consumer of the 32-channel pulse filter.
- Watches the filtered pulse vector for rising and falling edges.
- Stamps each edge with a free-running timestamp.
- Serialises edges through a round-robin arbiter into a small event FIFO with a valid/ready output, for the register/telemetry side to drain.

---
 rtl/pulse_evt_pkg.sv | 17 +
 rtl/pulse_event_capture_if.sv | 18 +
 rtl/pulse_evt_fifo.sv | 55 +++++
 rtl/pulse_event_capture.sv | 142 ++++++++++++++
 tb/tb_pulse_event_capture.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pulse_evt_pkg.sv
// Shared types and width constants for the pulse event capture block.
// evt_t is the event FIFO entry: channel index, edge direction and timestamp.
package pulse_evt_pkg;

  localparam int unsigned NUM_CH     = 32;
  localparam int unsigned TS_W       = 32;
  localparam int unsigned CH_W       = $clog2(NUM_CH);
  localparam int unsigned FIFO_DEPTH = 16;

  // Field widths are the maximum supported; narrower instances zero-extend into them.
  typedef struct packed {
    logic [CH_W-1:0] chan;
    logic            rise;
    logic [TS_W-1:0] ts;
  } evt_t;

endpackage

// File: rtl/pulse_event_capture_if.sv
// Event output handshake of pulse_event_capture.
//   master: drives ev_valid/ev_chan/ev_rise/ev_time, samples ev_ready
//   slave : the consumer side (register/telemetry drain)
interface pulse_event_capture_if #(
  parameter int unsigned CH_W = 5,
  parameter int unsigned TS_W = 32
) ();

  logic            ev_valid;
  logic            ev_ready;
  logic [CH_W-1:0] ev_chan;
  logic            ev_rise;
  logic [TS_W-1:0] ev_time;

  modport master (output ev_valid, ev_chan, ev_rise, ev_time, input ev_ready);
  modport slave  (input ev_valid, ev_chan, ev_rise, ev_time, output ev_ready);

endinterface

// File: rtl/pulse_evt_fifo.sv
// Synchronous show-ahead FIFO of evt_t.
//   push_i/wdata_i : write; accepted when not full, or when full and popping
//   pop_i          : remove head; ignored when empty
//   rdata_o        : head entry, forced to zero when empty
//   full_o/empty_o/level_o : occupancy status (level 0..DEPTH)
module pulse_evt_fifo
  import pulse_evt_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  evt_t                     wdata_i,
  input  logic                     pop_i,
  output evt_t                     rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  evt_t          mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [LW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == LW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign level_o = cnt_q;
  // Stale storage is never visible: an empty FIFO presents an all-zero head.
  assign rdata_o = empty_o ? '0 : mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      if (do_push && !do_pop)      cnt_q <= cnt_q + LW'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - LW'(1);
    end
  end

endmodule

// File: rtl/pulse_event_capture.sv
// Edge capture for the filtered pulse vector. Each rising/falling edge is stamped
// with a free-running cycle counter, parked in a per-channel pending slot, and
// moved by a round-robin arbiter (one per cycle) into a show-ahead event FIFO.
//   clk, rst_n     : clock, async active-low reset
//   pulse_in_i     : filtered pulses, synchronous to clk
//   clr_i          : single-cycle clear of the sticky overflow flag
//   ev_if          : event handshake (valid/ready, chan, rise, time)
//   fifo_level_o   : FIFO occupancy 0..FIFO_DEPTH
//   overflow_o     : sticky, an edge was dropped on an occupied pending slot
module pulse_event_capture #(
  parameter int unsigned NUM_CH     = 32,
  parameter int unsigned TS_W       = 32,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CH-1:0]             pulse_in_i,
  input  logic                          clr_i,
  pulse_event_capture_if.master         ev_if,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          overflow_o
);

  import pulse_evt_pkg::*;

  localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [TS_W-1:0]   ts_q;
  logic [NUM_CH-1:0] prev_q;
  logic [NUM_CH-1:0] pend_q, pend_d, prise_q, prise_d;
  logic [TS_W-1:0]   ptime_q [NUM_CH];
  logic [TS_W-1:0]   ptime_d [NUM_CH];
  logic [CW-1:0]     rr_q, rr_d;
  logic              ovf_q, ovf_d;

  logic [NUM_CH-1:0] chg;
  logic              found, grant, drop, pop, fifo_full, fifo_empty;
  logic [CW-1:0]     gnt_chan;
  evt_t              wdata, rdata;

  assign chg = pulse_in_i ^ prev_q;
  assign pop = ~fifo_empty & ev_if.ev_ready;

  // First pending channel at or after rr_q, circularly.
  always_comb begin
    int unsigned idx;
    logic [CW-1:0] idx_c;
    found    = 1'b0;
    gnt_chan = '0;
    idx      = 0;
    idx_c    = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx = int'(unsigned'(rr_q)) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      idx_c = CW'(idx);
      if (!found && pend_q[idx_c]) begin
        found    = 1'b1;
        gnt_chan = idx_c;
      end
    end
  end

  // A full FIFO still takes a write when its head leaves in the same cycle.
  assign grant = found & (~fifo_full | pop);

  always_comb begin
    wdata                = '0;
    wdata.chan[CW-1:0]   = gnt_chan;
    wdata.rise           = prise_q[gnt_chan];
    wdata.ts[TS_W-1:0]   = ptime_q[gnt_chan];
  end

  always_comb begin
    pend_d  = pend_q;
    prise_d = prise_q;
    ptime_d = ptime_q;
    drop    = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (chg[i]) begin
        // Slot drained by this cycle's grant is free for the new edge.
        if (pend_q[i] && !(grant && gnt_chan == CW'(i))) begin
          drop = 1'b1;
        end else begin
          pend_d[i]  = 1'b1;
          prise_d[i] = pulse_in_i[i];
          ptime_d[i] = ts_q;
        end
      end else if (grant && gnt_chan == CW'(i)) begin
        pend_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (grant) rr_d = (gnt_chan == CW'(NUM_CH - 1)) ? '0 : gnt_chan + CW'(1);
  end

  // Drop takes priority over a same-cycle clear.
  assign ovf_d = (ovf_q & ~clr_i) | drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q    <= '0;
      prev_q  <= '0;
      pend_q  <= '0;
      prise_q <= '0;
      ptime_q <= '{default: '0};
      rr_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      ts_q    <= ts_q + TS_W'(1);
      prev_q  <= pulse_in_i;
      pend_q  <= pend_d;
      prise_q <= prise_d;
      ptime_q <= ptime_d;
      rr_q    <= rr_d;
      ovf_q   <= ovf_d;
    end
  end

  pulse_evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (grant),
    .wdata_i (wdata),
    .pop_i   (pop),
    .rdata_o (rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level_o)
  );

  assign ev_if.ev_valid = ~fifo_empty;
  assign ev_if.ev_chan  = rdata.chan[CW-1:0];
  assign ev_if.ev_rise  = rdata.rise;
  assign ev_if.ev_time  = rdata.ts[TS_W-1:0];
  assign overflow_o     = ovf_q;

endmodule

// File: tb/tb_pulse_event_capture.sv
// Randomised and directed bench for pulse_event_capture with an 8-bit timestamp
// so wrap-around is reached quickly. A transaction-level model predicts events
// into a scoreboard queue; a negedge monitor compares on every handshake.
module tb_pulse_event_capture;

  localparam int unsigned NUM_CH = 32;
  localparam int unsigned TS_W   = 8;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned CW     = 5;
  localparam int unsigned LW     = 5;
  localparam int          TS_MOD = 1 << TS_W;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b1;
  logic [NUM_CH-1:0] pulse = '0;
  logic              clr   = 1'b0;
  logic [LW-1:0]     level;
  logic              ovf;

  pulse_event_capture_if #(.CH_W(CW), .TS_W(TS_W)) ev_if ();

  pulse_event_capture #(
    .NUM_CH     (NUM_CH),
    .TS_W       (TS_W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pulse_in_i   (pulse),
    .clr_i        (clr),
    .ev_if        (ev_if),
    .fifo_level_o (level),
    .overflow_o   (ovf)
  );

  always #25 clk = ~clk;

  typedef struct {
    int chan;
    bit rise;
    int t;
  } ev_s;

  int  checks = 0;
  int  errors = 0;
  ev_s exp_q[$];
  ev_s mfifo[$];
  bit  mpend[NUM_CH];
  bit  mrise[NUM_CH];
  int  mtime[NUM_CH];
  bit  mprev[NUM_CH];
  int  mrr, mts;
  bit  movf;

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      mpend[i] = 0; mrise[i] = 0; mtime[i] = 0; mprev[i] = 0;
    end
    mrr = 0; mts = 0; movf = 0;
    mfifo.delete();
    exp_q.delete();
  endtask

  // One clock of the behaviour: pop, one round-robin grant, edge capture/drop,
  // overflow update, timestamp advance.
  task automatic model_step();
    bit  pop, found, grant, drop;
    int  chan, c;
    ev_s e;
    pop   = (mfifo.size() > 0) && ev_if.ev_ready;
    found = 0;
    chan  = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      c = (mrr + k) % NUM_CH;
      if (!found && mpend[c]) begin found = 1; chan = c; end
    end
    grant = found && (mfifo.size() < DEPTH || pop);
    if (pop) void'(mfifo.pop_front());
    if (grant) begin
      e.chan = chan; e.rise = mrise[chan]; e.t = mtime[chan];
      mfifo.push_back(e);
      exp_q.push_back(e);
      mpend[chan] = 0;
      mrr = (chan + 1) % NUM_CH;
    end
    drop = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pulse[i] != mprev[i]) begin
        if (mpend[i]) drop = 1;
        else begin mpend[i] = 1; mrise[i] = pulse[i]; mtime[i] = mts; end
      end
    end
    if (clr)  movf = 0;
    if (drop) movf = 1;
    for (int i = 0; i < NUM_CH; i++) mprev[i] = pulse[i];
    mts = (mts + 1) % TS_MOD;
  endtask

  // Monitor: outputs are stable at the negedge; a valid&ready seen here is
  // the handshake that completes at the following posedge.
  initial begin
    ev_s e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("ev_valid", ev_if.ev_valid, mfifo.size() > 0);
        check("fifo_level", level, mfifo.size());
        check("overflow", ovf, movf);
        if (ev_if.ev_valid && ev_if.ev_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_event", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("ev_chan", ev_if.ev_chan, e.chan);
            check("ev_rise", ev_if.ev_rise, e.rise);
            check("ev_time", ev_if.ev_time, e.t);
          end
        end
      end
    end
  end

  task automatic cyc(input logic [NUM_CH-1:0] p, input bit rdy, input bit c);
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    pulse          = p;
    ev_if.ev_ready = rdy;
    clr            = c;
  endtask

  // Advance so that the next cyc() drives its input in the cycle where ts == target.
  task automatic wait_ts(input logic [NUM_CH-1:0] p, input int target);
    for (int k = 0; k < 2 * TS_MOD && mts != (target + TS_MOD - 1) % TS_MOD; k++) cyc(p, 1, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, ev_if.ev_valid, 0);
    check({tag, "_chan"}, ev_if.ev_chan, 0);
    check({tag, "_rise"}, ev_if.ev_rise, 0);
    check({tag, "_time"}, ev_if.ev_time, 0);
    check({tag, "_level"}, level, 0);
    check({tag, "_ovf"}, ovf, 0);
  endtask

  initial begin
    logic [NUM_CH-1:0] p;
    logic [NUM_CH-1:0] m;
    bit                rdy;
    ev_if.ev_ready = 1'b0;
    model_reset();
    #5 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    rst_n = 1'b1;

    // Simultaneous rises from rr=0, then rotation after a grant on ch10.
    p = '0; p[3] = 1; p[7] = 1; p[31] = 1;
    cyc(p, 1, 0);
    repeat (6) cyc(p, 1, 0);
    p[10] = 1; cyc(p, 1, 0);
    repeat (4) cyc(p, 1, 0);
    p[3] = 0; p[31] = 0; cyc(p, 1, 0);
    repeat (6) cyc(p, 1, 0);

    // Single pulse on ch0 at ts=100, fall at ts=2100 mod 256.
    wait_ts(p, 100);
    p[0] = 1; cyc(p, 1, 0);
    cyc(p, 1, 0);
    check("lat_n1_valid", ev_if.ev_valid, 0);
    cyc(p, 1, 0);
    check("lat_n2_valid", ev_if.ev_valid, 1);
    check("lat_chan", ev_if.ev_chan, 0);
    check("lat_rise", ev_if.ev_rise, 1);
    check("lat_time", ev_if.ev_time, 100);
    wait_ts(p, 2100 % TS_MOD);
    p[0] = 0; cyc(p, 1, 0);
    repeat (4) cyc(p, 1, 0);

    // Backpressure: rr brought to 0 via ch31, then 20 rises into a 16-deep FIFO.
    p = '0; cyc(p, 1, 0);
    repeat (6) cyc(p, 1, 0);
    p[31] = 1; cyc(p, 1, 0);
    repeat (4) cyc(p, 1, 0);
    p[19:0] = '1; cyc(p, 0, 0);
    repeat (25) cyc(p, 0, 0);
    check("bp_level", level, 16);
    check("bp_head_chan", ev_if.ev_chan, 0);
    check("bp_ovf", ovf, 0);
    repeat (30) cyc(p, 1, 0);
    check("bp_drained", level, 0);

    // Overflow: full FIFO, ch5 rises then falls while pending.
    p[19:0] = '0; cyc(p, 1, 0);
    repeat (40) cyc(p, 1, 0);
    p[23:8] = '1; cyc(p, 0, 0);
    repeat (20) cyc(p, 0, 0);
    check("ovf_full_level", level, 16);
    p[5] = 1; cyc(p, 0, 0);
    repeat (2) cyc(p, 0, 0);
    p[5] = 0; cyc(p, 0, 0);
    repeat (2) cyc(p, 0, 0);
    check("ovf_set", ovf, 1);
    cyc(p, 0, 1);
    cyc(p, 0, 0);
    check("ovf_cleared", ovf, 0);
    p[5] = 1; cyc(p, 0, 1);
    cyc(p, 0, 0);
    check("ovf_set_wins", ovf, 1);
    cyc(p, 1, 1);
    repeat (40) cyc(p, 1, 0);

    // Timestamp wrap: edges at ts=255 and ts=1.
    wait_ts(p, 255);
    p[1] = ~p[1]; cyc(p, 1, 0);
    cyc(p, 1, 0);
    p[2] = ~p[2]; cyc(p, 1, 0);
    repeat (6) cyc(p, 1, 0);
    check("wrap_empty", level, 0);

    // Reset mid-operation with 5 queued and 3 pending.
    p[15:8] = ~p[15:8]; cyc(p, 0, 0);
    repeat (6) cyc(p, 0, 0);
    check("prerst_level", level, 5);
    #1 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    model_reset();
    p = '0; p[20] = 1;
    cyc(p, 1, 0);
    cyc(p, 1, 0);
    rst_n = 1'b1;
    cyc(p, 1, 0);
    cyc(p, 1, 0);
    check("postrst_valid", ev_if.ev_valid, 1);
    check("postrst_chan", ev_if.ev_chan, 20);
    check("postrst_rise", ev_if.ev_rise, 1);
    check("postrst_time", ev_if.ev_time, 0);
    repeat (4) cyc(p, 1, 0);

    // Random traffic with bursty backpressure and occasional clears.
    rdy = 1;
    for (int n = 0; n < 3000; n++) begin
      m = NUM_CH'($urandom & $urandom & $urandom & $urandom & $urandom & $urandom);
      p = p ^ m;
      if ($urandom_range(0, 19) == 0) rdy = ~rdy;
      cyc(p, rdy ? ($urandom_range(0, 3) != 0) : 1'b0, $urandom_range(0, 99) == 0);
    end
    repeat (80) cyc(p, 1, 0);
    check("final_scoreboard_empty", exp_q.size(), 0);
    check("final_level", level, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
